// File: rtl/led_adder_if.sv
// Board-pin bundle for led_adder: four switch inputs and four LED outputs.
// The slave modport is the adder's view; the master modport drives the switches.
interface led_adder_if;
   logic sw1;
   logic sw2;
   logic sw3;
   logic sw4;
   logic LED_1;
   logic LED_2;
   logic LED_3;
   logic LED_4;

   modport master (
      output sw1, sw2, sw3, sw4,
      input  LED_1, LED_2, LED_3, LED_4
   );

   modport slave (
      input  sw1, sw2, sw3, sw4,
      output LED_1, LED_2, LED_3, LED_4
   );
endinterface

// File: rtl/led_adder.sv
// Two-bit switch adder driving four LEDs through synchronizers and registered outputs.
// Define LED_ADDER_DEBOUNCE_EN to insert a per-switch debounce filter of DEBOUNCE_CYCLES.
module led_adder #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input logic        clk,
   input logic        rst_n,
   led_adder_if.slave board_io
);

   logic [3:0] sw_raw;
   logic [3:0] s1_q;
   logic [3:0] s2_q;
   logic [3:0] filt;
   logic [3:0] sum;
   logic [3:0] led_q;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("led_adder: DEBOUNCE_CYCLES must be at least 1");
   end

   // Bit order {B[1], B[0], A[1], A[0]}.
   assign sw_raw = {board_io.sw4, board_io.sw3, board_io.sw2, board_io.sw1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= sw_raw;
         s2_q <= s1_q;
      end
   end

`ifdef LED_ADDER_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]      deb_q;
   logic [3:0]      deb_d;
   logic [CntW-1:0] cnt_q [4];
   logic [CntW-1:0] cnt_d [4];

   // Any sample agreeing with the accepted state restarts the count.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            deb_d[i] = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_q <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign filt = deb_q;
`else
   assign filt = s2_q;
`endif

   assign sum = {2'b00, filt[1:0]} + {2'b00, filt[3:2]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_q <= '0;
      end else begin
         led_q <= sum;
      end
   end

   assign board_io.LED_1 = led_q[3];
   assign board_io.LED_2 = led_q[2];
   assign board_io.LED_3 = led_q[1];
   assign board_io.LED_4 = led_q[0];

endmodule

// File: tb/tb_led_adder.sv
// Self-checking bench for led_adder: a sample-history model of the switch path checked
// every cycle, plus directed reset, sweep, latency, glitch and pulse checks.
module tb_led_adder;

   localparam int unsigned Deb = 4;
`ifdef LED_ADDER_DEBOUNCE_EN
   localparam int Lat = 2 + Deb;
`else
   localparam int Lat = 2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   led_adder_if u_if ();

   led_adder #(.DEBOUNCE_CYCLES(Deb)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .board_io (u_if)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] leds();
      return {u_if.LED_1, u_if.LED_2, u_if.LED_3, u_if.LED_4};
   endfunction

   function automatic logic [3:0] add_ab(input logic [3:0] v);
      int a;
      int b;
      a = int'(v[1:0]);
      b = int'(v[3:2]);
      return 4'(a + b);
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic set_sw(input logic [3:0] v);
      {u_if.sw4, u_if.sw3, u_if.sw2, u_if.sw1} = v;
   endtask

   // Model: filter input at edge k is the switch sample from edge k-2, zeroed if a reset
   // edge lies at or after that sample; a switch is accepted once Deb consecutive
   // filter inputs all disagree with the accepted value.
   logic [3:0] samp_h [$];
   logic [3:0] fin_h [$];
   logic [3:0] exp_led = '0;
   logic [3:0] mdeb = '0;
   bit         mvalid = 1'b0;

   initial begin
      int k;
      int lastrst;
      logic [3:0] fin;
      k = 0;
      lastrst = 0;
      forever begin
         @(posedge clk);
         samp_h.push_back({u_if.sw4, u_if.sw3, u_if.sw2, u_if.sw1});
         if (!rst_n) begin
            lastrst = k;
            mdeb = '0;
            exp_led = '0;
            mvalid = 1'b1;
            fin_h.push_back(4'b0000);
         end else begin
            fin = (k >= 2 && k - 2 > lastrst) ? samp_h[k-2] : 4'b0000;
            fin_h.push_back(fin);
`ifdef LED_ADDER_DEBOUNCE_EN
            exp_led = add_ab(mdeb);
            for (int b = 0; b < 4; b++) begin
               bit flip;
               flip = (k - int'(Deb) + 1 > lastrst);
               for (int i = 0; i < int'(Deb); i++) begin
                  if (flip && fin_h[k-i][b] == mdeb[b]) flip = 1'b0;
               end
               if (flip) mdeb[b] = ~mdeb[b];
            end
`else
            exp_led = add_ab(fin);
`endif
         end
         k++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mvalid) check("model", leds(), exp_led);
      end
   end

   initial begin
      logic [3:0] v;
      // Reset held with every switch on.
      set_sw(4'b1111);
      rst_n = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("rst_hold", leds(), 4'b0000);
      end
      rst_n = 1'b1;
      repeat (Lat + 3) @(negedge clk);
      check("rst_release", leds(), 4'b0110);

      // Sweep of {sw2, sw1, sw4, sw3} = i.
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         {u_if.sw2, u_if.sw1, u_if.sw4, u_if.sw3} = v;
         repeat (20) @(negedge clk);
         check("sweep", leds(), 4'(int'(v[3:2]) + int'(v[1:0])));
         if (i == 5)  check("sweep_i5", leds(), 4'b0010);
         if (i == 10) check("sweep_i10", leds(), 4'b0100);
         if (i == 15) check("sweep_i15", leds(), 4'b0110);
      end

      // Latency of a single sw1 step.
      set_sw(4'b0000);
      repeat (Lat + 6) @(negedge clk);
      u_if.sw1 = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= Lat; i++) begin
         @(posedge clk);
         #1;
         if (i == Lat - 1) check("lat_early", {3'b000, u_if.LED_4}, 4'b0000);
         if (i == Lat) check("lat_edge", {3'b000, u_if.LED_4}, 4'b0001);
      end
      @(negedge clk);
      set_sw(4'b0000);
      repeat (Lat + 6) @(negedge clk);

`ifdef LED_ADDER_DEBOUNCE_EN
      // Three-cycle glitch on sw3 must never reach the LEDs.
      u_if.sw3 = 1'b1;
      repeat (3) @(negedge clk);
      u_if.sw3 = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("glitch", leds(), 4'b0000);
      end

      // Reset after the sw4 count has reached 2.
      u_if.sw4 = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst", leds(), 4'b0000);
      rst_n = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      check("mid_rst_early", leds(), 4'b0000);
      @(posedge clk);
      #1;
      check("mid_rst_full", leds(), 4'b0010);
`else
      // One-cycle sw2 pulse reproduced on LED_3.
      u_if.sw2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      u_if.sw2 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         check("pulse", {2'b00, u_if.LED_3, 1'b0}, (i == 2) ? 4'b0010 : 4'b0000);
      end
`endif
      @(negedge clk);
      set_sw(4'b0000);
      repeat (10) @(negedge clk);

      // Random switch activity with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if ($urandom_range(199) == 0) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
            if ($urandom_range(3) == 0) set_sw(4'($urandom_range(15)));
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (Lat + 6) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_adder.md
# led_adder

Two-bit adder for the iCE40 board that treats switch pairs as operands and shows the sum on four LEDs. Operand A is {sw2, sw1}, operand B is {sw4, sw3}, and the 4-bit sum appears on LED_1 (MSB) through LED_4 (LSB). The block is a top-level leaf driven directly by board pins. It synchronizes the switches, optionally debounces them, and registers the outputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required before a switch change is accepted. Legal range ≥1. Used only when debounce is compiled in.

Ports:
- clk  input  1  system clock. One clock domain only.
- rst_n  input  1  reset; synchronous, active-low.
- sw1  input  1  operand A bit 0. Asynchronous to clk.
- sw2  input  1  operand A bit 1. Asynchronous to clk.
- sw3  input  1  operand B bit 0. Asynchronous to clk.
- sw4  input  1  operand B bit 1. Asynchronous to clk.
- LED_1  output  1  sum bit 3. Always 0, because the maximum sum is 6.
- LED_2  output  1  sum bit 2 (carry out).
- LED_3  output  1  sum bit 1.
- LED_4  output  1  sum bit 0.

## Operation
- Each switch passes through its own two-flop synchronizer (s1, then s2).
- Optional per-switch debounce filter:
  - Holds a debounced state `deb` and a counter `cnt` of width $clog2(DEBOUNCE_CYCLES)+1.
  - When s2 == deb: cnt <= 0.
  - When s2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s2 and cnt <= 0.
  - Otherwise cnt <= cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES edges resets the count and is never accepted.
- Arithmetic: sum[3:0] = {2'b00, A} + {2'b00, B}, unsigned. Carry cannot overflow 4 bits.
- The sum is registered. {LED_1, LED_2, LED_3, LED_4} <= sum[3:0].
- Switch inputs are treated as active-high; inversion for board polarity happens outside this block.
- All four switches are independent. Simultaneous changes on any subset are handled per switch, with no ordering between them.

## Timing
- While rst_n = 0 at a rising edge, the following are cleared to 0 at that edge:
  - all synchronizer flops,
  - deb and cnt,
  - all LED outputs.
- Outputs read 0000 for the whole of reset and for the first edges after release, until new switch values propagate.
- Latency without debounce: a switch value sampled at edge n appears on the LEDs after edge n+2.
- Latency with debounce: the value sampled at edge n, held stable, appears after edge n+2+DEBOUNCE_CYCLES.
- Reset asserted mid-operation: the next edge clears everything, including partially counted debounce.
- After reset release, switches already high are accepted through the normal latency path.
- Outputs are glitch-free, driven directly from flops.

## Configuration
- Macro LED_ADDER_DEBOUNCE_EN.
- Defined: the debounce filter sits between the synchronizer and the adder, and DEBOUNCE_CYCLES applies.
- Undefined: the synchronizer output feeds the adder directly. DEBOUNCE_CYCLES is ignored, no counters are synthesized, and latency is 3 edges.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with all switches = 1 -> LEDs = 0000 throughout. Release -> LEDs = 0110 after the stated latency.
- Exhaustive sweep, DEBOUNCE_CYCLES=4, for i = 0..15:
  - {sw2, sw1, sw4, sw3} = i, held 20 cycles -> LEDs = A+B.
  - Example: i=5 (A=1, B=1) -> 0010.
  - Example: i=15 (A=3, B=3) -> 0110.
  - Example: i=10 (A=2, B=2) -> 0100.
- Latency check: with the macro defined, DEBOUNCE_CYCLES=4, step sw1 0->1 before edge n -> LED_4 rises exactly after edge n+6, not earlier.
- Glitch rejection: with the macro defined, pulse sw3 high for 3 cycles (fewer than 4) -> LEDs unchanged.
- Reset mid-debounce: start a sw4 change, assert rst_n=0 at count 2 -> all state is 0. After release, the change needs the full latency again.
- Macro undefined: toggle sw2 for 1 cycle -> the 1-cycle pulse appears on LED_3 delayed by 3 edges.
